jtag_tap_ctrl: RTL and testbench

IEEE 1149.1-style TAP controller and instruction register that drive the JTAG data-register chains (IDCODE, BYPASS, optional USER). It runs the 16-state TAP state machine from TMS and holds and decodes the instruction register. It generates per-chain select and load strobes compatible with the IDCODE chain contract: shift while selected, parallel-load when the load strobe is also high. It multiplexes the selected chain's serial output onto TDO.

---
 rtl/jtag_pkg.sv | 42 ++++
 rtl/jtag_tap_fsm.sv | 55 +++++
 rtl/jtag_tap_ctrl.sv | 155 +++++++++++++++
 tb/tb_jtag_tap_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// ----------------------------------------------------------------------------
// jtag_pkg
// Shared definitions for the JTAG TAP controller slice:
//   - the 16 TAP state encodings (4-bit, IEEE 1149.1 style numbering)
//   - default opcodes for IDCODE, BYPASS and USER
//   - the fixed low bits captured into the IR shift register in Capture-IR
//   - a packed struct describing which data-register chain is selected
// ----------------------------------------------------------------------------
package jtag_pkg;

  localparam logic [3:0] TAP_TLR    = 4'hF;
  localparam logic [3:0] TAP_RTI    = 4'hC;
  localparam logic [3:0] TAP_SEL_DR = 4'h7;
  localparam logic [3:0] TAP_CAP_DR = 4'h6;
  localparam logic [3:0] TAP_SH_DR  = 4'h2;
  localparam logic [3:0] TAP_EX1_DR = 4'h1;
  localparam logic [3:0] TAP_PAU_DR = 4'h3;
  localparam logic [3:0] TAP_EX2_DR = 4'h0;
  localparam logic [3:0] TAP_UPD_DR = 4'h5;
  localparam logic [3:0] TAP_SEL_IR = 4'h4;
  localparam logic [3:0] TAP_CAP_IR = 4'hE;
  localparam logic [3:0] TAP_SH_IR  = 4'hA;
  localparam logic [3:0] TAP_EX1_IR = 4'h9;
  localparam logic [3:0] TAP_PAU_IR = 4'hB;
  localparam logic [3:0] TAP_EX2_IR = 4'h8;
  localparam logic [3:0] TAP_UPD_IR = 4'hD;

  localparam logic [3:0] IDCODE_OP_DEF = 4'b0001;
  localparam logic [3:0] BYPASS_OP_DEF = 4'b1111;
  localparam logic [3:0] USER_OP_DEF   = 4'b1000;

  // Low two bits captured in Capture-IR; upper bits are zero-filled.
  localparam logic [1:0] CAP_IR_LSBS = 2'b01;

  // Exactly one field is set for any instruction held in the IR.
  typedef struct packed {
    logic idcode;
    logic user;
    logic bypass;
  } dr_sel_t;

endpackage

// File: rtl/jtag_tap_fsm.sv
// ----------------------------------------------------------------------------
// jtag_tap_fsm
// The 16-state TAP state machine: state register plus next-state logic only.
// Ports:
//   CLK       in   TCK-equivalent clock, state advances on posedge
//   RST_N     in   asynchronous active-low reset, forces Test-Logic-Reset
//   TMS       in   test mode select, sampled on posedge CLK
//   TAP_STATE out  current state encoding (see jtag_pkg)
// ----------------------------------------------------------------------------
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       TMS,
  output logic [3:0] TAP_STATE
);

  logic [3:0] state;
  logic [3:0] state_nxt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= TAP_TLR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = TAP_TLR;
    case (state)
      TAP_TLR:    state_nxt = TMS ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    state_nxt = TMS ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: state_nxt = TMS ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: state_nxt = TMS ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  state_nxt = TMS ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: state_nxt = TMS ? TAP_UPD_DR : TAP_PAU_DR;
      TAP_PAU_DR: state_nxt = TMS ? TAP_EX2_DR : TAP_PAU_DR;
      TAP_EX2_DR: state_nxt = TMS ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: state_nxt = TMS ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: state_nxt = TMS ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: state_nxt = TMS ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  state_nxt = TMS ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: state_nxt = TMS ? TAP_UPD_IR : TAP_PAU_IR;
      TAP_PAU_IR: state_nxt = TMS ? TAP_EX2_IR : TAP_PAU_IR;
      TAP_EX2_IR: state_nxt = TMS ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR: state_nxt = TMS ? TAP_SEL_DR : TAP_RTI;
      default:    state_nxt = TAP_TLR;
    endcase
  end

  assign TAP_STATE = state;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// ----------------------------------------------------------------------------
// jtag_tap_ctrl
// TAP controller top: runs the TAP FSM, holds the instruction register,
// implements the 1-bit BYPASS register, decodes per-chain select/load
// strobes and muxes the selected serial output onto TDO.
//
// Optional feature macro: JTAG_USER_DR_EN
//   defined   -> USER_OP selects the USER chain; SEL_USER / USER_SO exist
//   undefined -> those ports are absent and USER_OP decodes to BYPASS
//
// Chain contract: a chain shifts on posedge while its SEL_* is high and
// parallel-loads instead when LOAD_CHAIN is also high (Capture-DR).
//
// Ports:
//   CLK, RST_N   clock and asynchronous active-low reset
//   TMS, TDI     JTAG inputs, sampled on posedge CLK
//   TDO, TDO_EN  serial output (combinational mux) and its enable
//   CHAIN_SI     serial input shared by all DR chains (TDI)
//   LOAD_CHAIN   high in Capture-DR
//   SEL_IDCODE   IDCODE chain select (Capture-DR/Shift-DR only)
//   IDCODE_SO    IDCODE chain serial output
//   SEL_USER     USER chain select (JTAG_USER_DR_EN only)
//   USER_SO      USER chain serial output (JTAG_USER_DR_EN only)
//   UPDATE_DR    high in Update-DR
//   TAP_STATE    current TAP state encoding (debug)
// ----------------------------------------------------------------------------
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int                  IR_WIDTH  = 4,
  parameter logic [IR_WIDTH-1:0] IDCODE_OP = IR_WIDTH'(IDCODE_OP_DEF),
  parameter logic [IR_WIDTH-1:0] BYPASS_OP = IR_WIDTH'(BYPASS_OP_DEF),
  parameter logic [IR_WIDTH-1:0] USER_OP   = IR_WIDTH'(USER_OP_DEF)
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       TMS,
  input  logic       TDI,
  output logic       TDO,
  output logic       TDO_EN,
  output logic       CHAIN_SI,
  output logic       LOAD_CHAIN,
  output logic       SEL_IDCODE,
  input  logic       IDCODE_SO,
`ifdef JTAG_USER_DR_EN
  output logic       SEL_USER,
  input  logic       USER_SO,
`endif
  output logic       UPDATE_DR,
  output logic [3:0] TAP_STATE
);

  localparam logic [IR_WIDTH-1:0] CAP_IR_VAL = {{(IR_WIDTH-2){1'b0}}, CAP_IR_LSBS};

  logic [3:0]          state;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [IR_WIDTH-1:0] ir_hold;
  logic                bypass_q;
  logic                dr_active;
  dr_sel_t             dr_sel;
  logic                tdo_c;

  jtag_tap_fsm u_fsm (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .TMS       (TMS),
    .TAP_STATE (state)
  );

  // Instruction register: shift stage and holding stage. The holding stage
  // only changes on the edge leaving Update-IR (or in Test-Logic-Reset), so
  // a reset mid-shift never commits a partial instruction.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ir_shift <= IDCODE_OP;
      ir_hold  <= IDCODE_OP;
    end else begin
      case (state)
        TAP_TLR: begin
          ir_shift <= IDCODE_OP;
          ir_hold  <= IDCODE_OP;
        end
        TAP_CAP_IR: ir_shift <= CAP_IR_VAL;
        TAP_SH_IR:  ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
        TAP_UPD_IR: ir_hold  <= ir_shift;
        default: ;
      endcase
    end
  end

  // Instruction decode; anything not explicitly recognised is BYPASS.
  always_comb begin
    dr_sel        = '0;
    dr_sel.idcode = (ir_hold == IDCODE_OP);
`ifdef JTAG_USER_DR_EN
    dr_sel.user   = (ir_hold == USER_OP) && !dr_sel.idcode;
`else
    dr_sel.user   = 1'b0;
`endif
    dr_sel.bypass = (ir_hold == BYPASS_OP) || !(dr_sel.idcode || dr_sel.user);
  end

`ifndef JTAG_USER_DR_EN
  logic unused_user_op;
  assign unused_user_op = ^USER_OP;
`endif

  // BYPASS register: cleared on capture, one-bit delay of TDI during shift.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bypass_q <= 1'b0;
    end else if (dr_sel.bypass) begin
      if (state == TAP_CAP_DR) begin
        bypass_q <= 1'b0;
      end else if (state == TAP_SH_DR) begin
        bypass_q <= TDI;
      end
    end
  end

  // Selects are confined to Capture-DR/Shift-DR so external chains hold
  // through pause, exit and update states.
  assign dr_active  = (state == TAP_CAP_DR) || (state == TAP_SH_DR);
  assign LOAD_CHAIN = (state == TAP_CAP_DR);
  assign SEL_IDCODE = dr_active && dr_sel.idcode;
`ifdef JTAG_USER_DR_EN
  assign SEL_USER   = dr_active && dr_sel.user;
`endif
  assign UPDATE_DR  = (state == TAP_UPD_DR);
  assign TDO_EN     = (state == TAP_SH_DR) || (state == TAP_SH_IR);
  assign CHAIN_SI   = TDI;
  assign TAP_STATE  = state;

  always_comb begin
    tdo_c = 1'b0;
    case (state)
      TAP_SH_IR: tdo_c = ir_shift[0];
      TAP_SH_DR: begin
        if (dr_sel.idcode) begin
          tdo_c = IDCODE_SO;
`ifdef JTAG_USER_DR_EN
        end else if (dr_sel.user) begin
          tdo_c = USER_SO;
`endif
        end else begin
          tdo_c = bypass_q;
        end
      end
      default: tdo_c = 1'b0;
    endcase
  end

  assign TDO = tdo_c;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// ----------------------------------------------------------------------------
// tb_jtag_tap_ctrl
// Directed bench for jtag_tap_ctrl. Inputs change on the falling edge; the
// outputs checked right after each drive() belong to the state whose exit is
// chosen by the TMS value just applied. Small behavioural IDCODE/USER chains
// (8'hA5 / 8'h3C) sit on the chain ports.
// ----------------------------------------------------------------------------
module tb_jtag_tap_ctrl;

  logic       CLK;
  logic       RST_N;
  logic       TMS;
  logic       TDI;
  logic       TDO;
  logic       TDO_EN;
  logic       CHAIN_SI;
  logic       LOAD_CHAIN;
  logic       SEL_IDCODE;
  logic       IDCODE_SO;
  logic       UPDATE_DR;
  logic [3:0] TAP_STATE;
`ifdef JTAG_USER_DR_EN
  logic       SEL_USER;
  logic       USER_SO;
  logic [7:0] user_chain;
`endif

  logic [7:0] idcode_chain;
  int         checks;
  int         errors;

  jtag_tap_ctrl dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .TMS        (TMS),
    .TDI        (TDI),
    .TDO        (TDO),
    .TDO_EN     (TDO_EN),
    .CHAIN_SI   (CHAIN_SI),
    .LOAD_CHAIN (LOAD_CHAIN),
    .SEL_IDCODE (SEL_IDCODE),
    .IDCODE_SO  (IDCODE_SO),
`ifdef JTAG_USER_DR_EN
    .SEL_USER   (SEL_USER),
    .USER_SO    (USER_SO),
`endif
    .UPDATE_DR  (UPDATE_DR),
    .TAP_STATE  (TAP_STATE)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // behavioural chains following the select/load contract
  always @(posedge CLK) begin
    if (SEL_IDCODE && LOAD_CHAIN) idcode_chain <= 8'hA5;
    else if (SEL_IDCODE)          idcode_chain <= {CHAIN_SI, idcode_chain[7:1]};
  end
  assign IDCODE_SO = idcode_chain[0];

`ifdef JTAG_USER_DR_EN
  always @(posedge CLK) begin
    if (SEL_USER && LOAD_CHAIN) user_chain <= 8'h3C;
    else if (SEL_USER)          user_chain <= {CHAIN_SI, user_chain[7:1]};
  end
  assign USER_SO = user_chain[0];
`endif

  // scoreboard check
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic tms, input logic tdi);
    @(negedge CLK);
    TMS = tms;
    TDI = tdi;
    #1;
  endtask

  // from pending RTI: ends in Capture-DR with TMS=0 applied
  task automatic dr_enter();
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
  endtask

  // from Exit1-DR back to pending RTI
  task automatic dr_exit();
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
  endtask

  // from pending RTI: shift op (LSB first) into IR, ends with pending RTI
  task automatic load_ir(input logic [3:0] op, output logic [3:0] tdo_bits);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(i == 3, op[i]);
      tdo_bits[i] = TDO;
    end
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
  endtask

  // five TMS=1 from the current state, then confirm TLR and IR reset value
  task automatic escape(input string tag);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    check({tag, "_state"}, {4'h0, TAP_STATE}, 8'h0F);
    drive(1'b0, 1'b0);
    check({tag, "_ir"}, {4'h0, dut.ir_hold}, 8'h01);
  endtask

  logic [3:0] ir_bits;
  logic [7:0] exp_id;
  logic [4:0] byp_tdi;
  logic [4:0] byp_tdo;

  initial begin
    checks  = 0;
    errors  = 0;
    RST_N   = 1'b1;
    TMS     = 1'b1;
    TDI     = 1'b0;
    exp_id  = 8'hA5;
    byp_tdi = 5'b01101;  // sent LSB first: 1,0,1,1,0
    byp_tdo = 5'b11010;  // expected LSB first: 0,1,0,1,1

    // reset asserted between clock edges
    #2 RST_N = 1'b0;
    #1;
    check("rst_state", {4'h0, TAP_STATE}, 8'h0F);
    check("rst_ir", {4'h0, dut.ir_hold}, 8'h01);
    check("rst_tdo", {7'h0, TDO}, 8'h00);
    check("rst_tdo_en", {7'h0, TDO_EN}, 8'h00);
    check("rst_load", {7'h0, LOAD_CHAIN}, 8'h00);
    check("rst_sel", {7'h0, SEL_IDCODE}, 8'h00);
    check("rst_upd", {7'h0, UPDATE_DR}, 8'h00);
    check("rst_bypass", {7'h0, dut.bypass_q}, 8'h00);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    drive(1'b0, 1'b0);
    check("tlr_hold", {4'h0, TAP_STATE}, 8'h0F);
    drive(1'b0, 1'b0);
    check("rti", {4'h0, TAP_STATE}, 8'h0C);

    // IDCODE read
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    check("sel_dr", {4'h0, TAP_STATE}, 8'h07);
    drive(1'b0, 1'b0);
    check("cap_state", {4'h0, TAP_STATE}, 8'h06);
    check("cap_load", {7'h0, LOAD_CHAIN}, 8'h01);
    check("cap_sel", {7'h0, SEL_IDCODE}, 8'h01);
    for (int i = 0; i < 8; i++) begin
      drive(i == 7, 1'b0);
      check("id_tdo", {7'h0, TDO}, {7'h0, exp_id[i]});
      if (i == 0) begin
        check("id_tdo_en", {7'h0, TDO_EN}, 8'h01);
        check("id_load_off", {7'h0, LOAD_CHAIN}, 8'h00);
      end
    end
    drive(1'b1, 1'b0);
    check("ex1_sel", {7'h0, SEL_IDCODE}, 8'h00);
    check("ex1_tdo_en", {7'h0, TDO_EN}, 8'h00);
    drive(1'b0, 1'b0);
    check("upd_dr", {7'h0, UPDATE_DR}, 8'h01);
    check("upd_state", {4'h0, TAP_STATE}, 8'h05);

    // load BYPASS and shift through it
    load_ir(4'hF, ir_bits);
    check("ir_tdo", {4'h0, ir_bits}, 8'h01);
    drive(1'b0, 1'b0);
    check("ir_byp", {4'h0, dut.ir_hold}, 8'h0F);
    dr_enter();
    check("byp_sel", {7'h0, SEL_IDCODE}, 8'h00);
    for (int i = 0; i < 5; i++) begin
      drive(i == 4, byp_tdi[i]);
      check("byp_tdo", {7'h0, TDO}, {7'h0, byp_tdo[i]});
    end
    dr_exit();

    // TLR escape from Shift-DR
    dr_enter();
    drive(1'b0, 1'b0);
    check("esc_sh_dr", {4'h0, TAP_STATE}, 8'h02);
    escape("esc_dr");

    // TLR escape from Pause-IR
    drive(1'b0, 1'b0);
    load_ir(4'hF, ir_bits);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    check("esc_pau_ir", {4'h0, TAP_STATE}, 8'h0B);
    escape("esc_pir");

    // TLR escape from RTI
    drive(1'b0, 1'b0);
    load_ir(4'hF, ir_bits);
    drive(1'b0, 1'b0);
    check("esc_rti", {4'h0, TAP_STATE}, 8'h0C);
    escape("esc_rti");

    // pause / resume during IDCODE shift
    drive(1'b0, 1'b0);
    dr_enter();
    for (int i = 0; i < 3; i++) begin
      drive(i == 2, 1'b0);
      check("pr_tdo_a", {7'h0, TDO}, {7'h0, exp_id[i]});
    end
    drive(1'b0, 1'b0);
    check("pr_ex1", {4'h0, TAP_STATE}, 8'h01);
    for (int k = 0; k < 4; k++) begin
      drive(k == 3, 1'b0);
      check("pr_pau_sel", {3'h0, SEL_IDCODE, TAP_STATE}, 8'h03);
    end
    drive(1'b0, 1'b0);
    check("pr_ex2", {4'h0, TAP_STATE}, 8'h00);
    for (int i = 3; i < 8; i++) begin
      drive(i == 7, 1'b0);
      check("pr_tdo_b", {7'h0, TDO}, {7'h0, exp_id[i]});
    end
    dr_exit();

    // reset in the middle of a DR shift
    dr_enter();
    drive(1'b0, 1'b0);
    check("mid_sel_on", {7'h0, SEL_IDCODE}, 8'h01);
    #2 RST_N = 1'b0;
    #1;
    check("mid_state", {4'h0, TAP_STATE}, 8'h0F);
    check("mid_sel_off", {7'h0, SEL_IDCODE}, 8'h00);
    check("mid_tdo_en", {7'h0, TDO_EN}, 8'h00);
    @(negedge CLK);
    RST_N = 1'b1;
    drive(1'b0, 1'b0);

    // USER opcode
    load_ir(4'b1000, ir_bits);
    drive(1'b0, 1'b0);
    check("ir_user", {4'h0, dut.ir_hold}, 8'h08);
    dr_enter();
    check("user_sel_id", {7'h0, SEL_IDCODE}, 8'h00);
`ifdef JTAG_USER_DR_EN
    check("user_sel", {7'h0, SEL_USER}, 8'h01);
    drive(1'b0, 1'b1);
    check("user_tdo0", {7'h0, TDO}, 8'h00);
    drive(1'b0, 1'b1);
    check("user_tdo1", {7'h0, TDO}, 8'h00);
    drive(1'b1, 1'b0);
    check("user_tdo2", {7'h0, TDO}, 8'h01);
`else
    drive(1'b0, 1'b1);
    check("user_byp0", {7'h0, TDO}, 8'h00);
    drive(1'b0, 1'b1);
    check("user_byp1", {7'h0, TDO}, 8'h01);
    drive(1'b1, 1'b0);
    check("user_byp2", {7'h0, TDO}, 8'h01);
`endif
    dr_exit();
    drive(1'b0, 1'b0);
    check("final_rti", {4'h0, TAP_STATE}, 8'h0C);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
